// File: rtl/gpr_pkg.sv
// gpr_pkg: shared definitions for the GPR writeback path.
//   WORD         - register width
//   GPR_AW       - register index width
//   gpr_wb_req_t - one writeback request (valid, destination register, data)
package gpr_pkg;

   localparam int WORD   = 32;
   localparam int GPR_AW = 5;

   typedef struct packed {
      logic              valid;
      logic [GPR_AW-1:0] addr;
      logic [WORD-1:0]   data;
   } gpr_wb_req_t;

endpackage

// File: rtl/gpr_wb_arbiter_if.sv
// gpr_wb_arbiter_if: bundle of the two writeback sources, the pipeline freeze,
// and the register-file write port.
//   master - the pipeline side: drives hold and both requests, sees readies,
//            busy and the write port
//   slave  - the arbiter: sees requests, drives readies, busy and write port
interface gpr_wb_arbiter_if;
   import gpr_pkg::*;

   logic              hold;
   logic              s0_valid;
   logic [GPR_AW-1:0] s0_addr;
   logic [WORD-1:0]   s0_data;
   logic              s0_ready;
   logic              s1_valid;
   logic [GPR_AW-1:0] s1_addr;
   logic [WORD-1:0]   s1_data;
   logic              s1_ready;
   logic              we;
   logic [GPR_AW-1:0] wr_addr;
   logic [WORD-1:0]   wr_data;
   logic              busy;

   modport master (
      output hold, s0_valid, s0_addr, s0_data, s1_valid, s1_addr, s1_data,
      input  s0_ready, s1_ready, we, wr_addr, wr_data, busy
   );

   modport slave (
      input  hold, s0_valid, s0_addr, s0_data, s1_valid, s1_addr, s1_data,
      output s0_ready, s1_ready, we, wr_addr, wr_data, busy
   );

endinterface

// File: rtl/gpr_wb_arbiter_prio_pick.sv
// gpr_wb_prio_pick: combinational grant selection for the GPR write port.
//   hold         in  - pipeline freeze, suppresses all grants
//   s0_valid     in  - source 0 (load data) request
//   s1_valid     in  - source 1 (ALU result) request
//   starve_force in  - source 1 has waited long enough and must win
//   grant0/1     out - one-hot (or zero) grant
module gpr_wb_prio_pick (
   input  logic hold,
   input  logic s0_valid,
   input  logic s1_valid,
   input  logic starve_force,
   output logic grant0,
   output logic grant1
);

   always_comb begin
      grant0 = 1'b0;
      grant1 = 1'b0;
      if (!hold) begin
         if (starve_force && s1_valid) begin
            grant1 = 1'b1;
         end else if (s0_valid) begin
            grant0 = 1'b1;
         end else if (s1_valid) begin
            grant1 = 1'b1;
         end
      end
   end

endmodule

// File: rtl/gpr_wb_arbiter.sv
// gpr_wb_arbiter: shares the GPR file's single write port between load
// writeback (source 0, fixed priority) and ALU writeback (source 1).
// The winning request is registered into the we/wr_addr/wr_data stage; writes
// to r0 are accepted but never raise we.
//   clk  in  - clock
//   rst  in  - asynchronous, active-low reset
//   bus  slave modport of gpr_wb_arbiter_if (requests, readies, write port, busy)
// Build option: GPR_WB_STARVE_EN adds a starvation counter that forces
// source 1 to win after STARVE_MAX consecutive denied cycles. Without it,
// priority is strictly fixed and STARVE_MAX is only range-checked.
module gpr_wb_arbiter
   import gpr_pkg::*;
#(
   parameter int STARVE_MAX = 4
) (
   input logic             clk,
   input logic             rst,
   gpr_wb_arbiter_if.slave bus
);

   if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_starve_max
      $error("gpr_wb_arbiter: STARVE_MAX must be in 1..15");
   end

   gpr_wb_req_t req0;
   gpr_wb_req_t req1;
   gpr_wb_req_t win;
   logic        grant0;
   logic        grant1;
   logic        starve_force;
   logic        xfer;

   always_comb begin
      req0.valid = bus.s0_valid;
      req0.addr  = bus.s0_addr;
      req0.data  = bus.s0_data;
      req1.valid = bus.s1_valid;
      req1.addr  = bus.s1_addr;
      req1.data  = bus.s1_data;
   end

`ifdef GPR_WB_STARVE_EN
   logic [3:0] starve_cnt;

   assign starve_force = (starve_cnt == 4'(STARVE_MAX));

   // Counts consecutive unfrozen cycles in which source 1 waits. It cannot
   // pass STARVE_MAX: once there, an unfrozen cycle with s1_valid grants s1.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         starve_cnt <= '0;
      end else if (!bus.hold) begin
         if (!bus.s1_valid || grant1) begin
            starve_cnt <= '0;
         end else begin
            starve_cnt <= starve_cnt + 4'd1;
         end
      end
   end
`else
   assign starve_force = 1'b0;
`endif

   gpr_wb_prio_pick u_pick (
      .hold         (bus.hold),
      .s0_valid     (bus.s0_valid),
      .s1_valid     (bus.s1_valid),
      .starve_force (starve_force),
      .grant0       (grant0),
      .grant1       (grant1)
   );

   assign win  = grant1 ? req1 : req0;
   assign xfer = (grant0 || grant1) && win.valid;

   assign bus.s0_ready = grant0;
   assign bus.s1_ready = grant1;
   assign bus.busy     = (bus.s0_valid && !grant0) || (bus.s1_valid && !grant1);

   // Address/data hold between transfers so the register file sees a stable
   // bus; only we pulses.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bus.we      <= 1'b0;
         bus.wr_addr <= '0;
         bus.wr_data <= '0;
      end else if (xfer) begin
         bus.we      <= (win.addr != '0);
         bus.wr_addr <= win.addr;
         bus.wr_data <= win.data;
      end else begin
         bus.we      <= 1'b0;
      end
   end

endmodule

// File: tb/tb_gpr_wb_arbiter.sv
module tb_gpr_wb_arbiter;

   localparam int SMAX = 4;
`ifdef GPR_WB_STARVE_EN
   localparam bit STARVE_EN = 1'b1;
`else
   localparam bit STARVE_EN = 1'b0;
`endif

   logic clk;
   logic rst;

   gpr_wb_arbiter_if bus ();

   gpr_wb_arbiter #(.STARVE_MAX(SMAX)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int total = 0;
   int fails = 0;

   // Reference model: how long source 1 has been kept waiting, and the
   // expected contents of the write port.
   int          streak;
   logic        m_we;
   logic [4:0]  m_addr;
   logic [31:0] m_data;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      streak = 0;
      m_we   = 1'b0;
      m_addr = '0;
      m_data = '0;
   endtask

   // One clock cycle: drive, check combinational outputs, clock, check the
   // registered write port. Called just after a rising edge (or mid-cycle).
   task automatic cycle(input logic h, input logic v0, input logic [4:0] a0,
                        input logic [31:0] d0, input logic v1, input logic [4:0] a1,
                        input logic [31:0] d1, output logic g0, output logic g1);
      bit frc;
      bus.hold     = h;
      bus.s0_valid = v0;
      bus.s0_addr  = a0;
      bus.s0_data  = d0;
      bus.s1_valid = v1;
      bus.s1_addr  = a1;
      bus.s1_data  = d1;
      #2;
      frc = STARVE_EN && (streak >= SMAX);
      g0 = 1'b0;
      g1 = 1'b0;
      if (!h) begin
         if (frc && v1)  g1 = 1'b1;
         else if (v0)    g0 = 1'b1;
         else if (v1)    g1 = 1'b1;
      end
      chk("s0_ready", bus.s0_ready, g0);
      chk("s1_ready", bus.s1_ready, g1);
      chk("busy", bus.busy, (v0 && !g0) || (v1 && !g1));
      if (g0 || g1) begin
         m_addr = g1 ? a1 : a0;
         m_data = g1 ? d1 : d0;
         m_we   = (m_addr != 0);
      end else begin
         m_we = 1'b0;
      end
      if (!h) streak = (!v1 || g1) ? 0 : streak + 1;
      @(posedge clk);
      #1;
      chk("we", bus.we, m_we);
      chk("wr_addr", bus.wr_addr, m_addr);
      chk("wr_data", bus.wr_data, m_data);
   endtask

   task automatic idle();
      logic g0, g1;
      cycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, g0, g1);
   endtask

   initial begin
      logic        g0, g1;
      logic        v0, v1, h;
      logic [4:0]  a0, a1;
      logic [31:0] d0, d1;
      int          first_s1;

      rst          = 1'b0;
      bus.hold     = 1'b0;
      bus.s0_valid = 1'b0;
      bus.s0_addr  = '0;
      bus.s0_data  = '0;
      bus.s1_valid = 1'b0;
      bus.s1_addr  = '0;
      bus.s1_data  = '0;
      model_reset();
      #12;
      chk("rst_we", bus.we, 1'b0);
      chk("rst_wr_addr", bus.wr_addr, 32'd0);
      chk("rst_wr_data", bus.wr_data, 32'd0);
      rst = 1'b1;

      // single source 1
      cycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'hDEADBEEF, g0, g1);
      chk("single_grant", g1, 1'b1);

      // collision: r3 first, r4 once s0 drops
      cycle(1'b0, 1'b1, 5'd3, 32'h3333_0003, 1'b1, 5'd4, 32'h4444_0004, g0, g1);
      cycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 32'h4444_0004, g0, g1);
      chk("collision_s1_after", g1, 1'b1);
      idle();

      // starvation: s0 continuously valid with fresh data each cycle
      first_s1 = 0;
      for (int i = 1; i <= 8; i++) begin
         cycle(1'b0, 1'b1, 5'(i + 8), $urandom, 1'b1, 5'd20, 32'hA5A5_1234, g0, g1);
         if (g1 && first_s1 == 0) first_s1 = i;
      end
      chk("starve_first_grant", first_s1, STARVE_EN ? SMAX + 1 : 0);
      idle();

      // r0 drop, then hold with both valid (streak must not move)
      cycle(1'b0, 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 5'd0, 32'd0, g0, g1);
      cycle(1'b0, 1'b1, 5'd6, 32'h0000_0006, 1'b1, 5'd7, 32'h0000_0007, g0, g1);
      cycle(1'b0, 1'b1, 5'd8, 32'h0000_0008, 1'b1, 5'd7, 32'h0000_0007, g0, g1);
      for (int i = 0; i < 3; i++)
         cycle(1'b1, 1'b1, 5'd9, 32'h0000_0009, 1'b1, 5'd7, 32'h0000_0007, g0, g1);
      for (int i = 0; i < 4; i++)
         cycle(1'b0, 1'b1, 5'(10 + i), $urandom, 1'b1, 5'd7, 32'h0000_0007, g0, g1);
      idle();

      // reset in the middle of a pending write
      cycle(1'b0, 1'b1, 5'd7, 32'hCAFE_F00D, 1'b0, 5'd0, 32'd0, g0, g1);
      bus.s0_valid = 1'b0;
      #2;
      rst = 1'b0;
      #1;
      chk("midrst_we", bus.we, 1'b0);
      chk("midrst_wr_addr", bus.wr_addr, 32'd0);
      chk("midrst_wr_data", bus.wr_data, 32'd0);
      #2;
      rst = 1'b1;
      model_reset();
      idle();
      idle();

      // randomized traffic; waiting sources keep their request stable
      v0 = 1'b0; v1 = 1'b0; a0 = '0; a1 = '0; d0 = '0; d1 = '0;
      g0 = 1'b0; g1 = 1'b0;
      for (int n = 0; n < 400; n++) begin
         if (!(v0 && !g0)) begin
            v0 = ($urandom_range(0, 9) < 6);
            a0 = 5'($urandom_range(0, 31));
            d0 = $urandom;
         end
         if (!(v1 && !g1)) begin
            v1 = ($urandom_range(0, 9) < 6);
            a1 = 5'($urandom_range(0, 31));
            d1 = $urandom;
         end
         h = ($urandom_range(0, 9) == 0);
         cycle(h, v0, a0, d0, v1, a1, d1, g0, g1);
      end

      $display("%0d/%0d checks passed", total - fails, total);
      $finish;
   end

endmodule
